// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/branch controls, instruction-memory port and IF/ID outputs.
// The master side is the fetch stage; the slave side is the surrounding core/testbench.
interface if_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 6
);
  logic              stall;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [XLEN-1:0]   if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [XLEN-1:0]   pc_out;
  logic              halted;
  logic              misaligned;
  logic [31:0]       fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid,
           pc_out, halted, misaligned, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
           pc_out, halted, misaligned, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, reads the 64-word instruction memory,
// fills the IF/ID register and handles stall, redirect, end-of-memory halt and misaligned-target fault.
module if_stage #(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    ADDR_W    = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]    NOP_INSTR = 32'h0000_0033
) (
  input  logic        i_clk,
  input  logic        i_rst,
  if_stage_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_if_id_pc;
  logic [31:0]       r_if_id_instr;
  logic              r_if_id_valid;
  logic              r_misaligned;
  logic [31:0]       r_fetch_count;

  logic              w_oor;
  logic              w_tgt_misaligned;

  // Out of range means any PC bit above the memory's byte-address span is set,
  // so the PC can never alias back into memory through imem_addr wrap-around.
  assign w_oor            = |r_pc[XLEN-1:ADDR_W+2];
  assign w_tgt_misaligned = |bus.branch_target[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else if (r_state == ST_FAULT) begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect beats stall: the branch is older than the stalled instruction.
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      if (w_tgt_misaligned) begin
        r_misaligned <= 1'b1;
        r_state      <= ST_FAULT;
      end else begin
        r_pc    <= bus.branch_target;
        r_state <= ST_RUN;
      end
    end else if (bus.stall) begin
      r_state <= r_state;
    end else if (r_state == ST_RUN) begin
      if (w_oor) begin
        r_state       <= ST_HALT;
        r_if_id_pc    <= '0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end else begin
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= bus.imem_data;
        r_if_id_valid <= 1'b1;
        r_pc          <= r_pc + XLEN'(4);
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end else begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end
  end

  assign bus.imem_addr   = r_pc[ADDR_W+1:2];
  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_valid = r_if_id_valid;
  assign bus.pc_out      = r_pc;
  assign bus.halted      = (r_state != ST_RUN);
  assign bus.misaligned  = r_misaligned;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes hand-computed post-edge state into a queue,
// a monitor pops and compares one entry after every rising edge.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0033;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        v;
    logic        h;
    logic        m;
    logic [31:0] fc;
    logic [5:0]  ia;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem [64];
  exp_t        q [$];
  int          total = 0;
  int          bad   = 0;

  if_stage_if #(.XLEN(32), .ADDR_W(6)) bus ();

  if_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = mem[bus.imem_addr];

  function automatic logic [31:0] w(input int i);
    if (i == 0) return 32'h0000_2083;
    return 32'hA000_0000 + 32'(i);
  endfunction

  // One clock of stimulus plus the state required after the coming edge.
  task automatic cyc(input string nm, input logic r, input logic st, input logic bt,
                     input logic [31:0] tgt, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                     input logic [31:0] e_instr, input logic e_v, input logic e_h,
                     input logic e_m, input logic [31:0] e_fc);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.stall         = st;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    e.name = nm;  e.pc = e_pc;  e.ipc = e_ipc;  e.instr = e_instr;
    e.v = e_v;    e.h = e_h;    e.m = e_m;      e.fc = e_fc;
    e.ia = e_pc[7:2];
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                      input logic [31:0] e_instr, input logic e_v, input logic e_h,
                      input logic e_m, input logic [31:0] e_fc);
    cyc(nm, 1'b0, 1'b0, 1'b0, 32'h0, e_pc, e_ipc, e_instr, e_v, e_h, e_m, e_fc);
  endtask

  // Monitor: compare the DUT against the oldest expectation just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (bus.pc_out !== e.pc || bus.if_id_pc !== e.ipc || bus.if_id_instr !== e.instr ||
            bus.if_id_valid !== e.v || bus.halted !== e.h || bus.misaligned !== e.m ||
            bus.fetch_count !== e.fc || bus.imem_addr !== e.ia) begin
          bad++;
          $display("FAIL %s: got pc=%h ipc=%h instr=%h v=%b h=%b m=%b fc=%0d ia=%0d want pc=%h ipc=%h instr=%h v=%b h=%b m=%b fc=%0d ia=%0d",
                   e.name, bus.pc_out, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid,
                   bus.halted, bus.misaligned, bus.fetch_count, bus.imem_addr,
                   e.pc, e.ipc, e.instr, e.v, e.h, e.m, e.fc, e.ia);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = w(i);
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;

    cyc("reset0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc("reset1", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);

    // Straight-line fetch from address 0.
    for (int k = 1; k <= 5; k++)
      idle("run", 32'(4 * k), 32'(4 * (k - 1)), w(k - 1), 1'b1, 1'b0, 1'b0, 32'(k));

    // Re-reset and run to 0x0C, then stall three edges.
    cyc("rst_again", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= 3; k++)
      idle("run2", 32'(4 * k), 32'(4 * (k - 1)), w(k - 1), 1'b1, 1'b0, 1'b0, 32'(k));
    for (int k = 0; k < 3; k++)
      cyc("stall_hold", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0C, 32'h08, w(2), 1'b1, 1'b0, 1'b0, 32'd3);
    idle("stall_release", 32'h10, 32'h0C, w(3), 1'b1, 1'b0, 1'b0, 32'd4);
    idle("run_to_14",     32'h14, 32'h10, w(4), 1'b1, 1'b0, 1'b0, 32'd5);

    // Redirect together with stall: redirect wins, one bubble.
    cyc("redir_vs_stall", 1'b0, 1'b1, 1'b1, 32'h20, 32'h20, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd5);
    idle("after_redir",   32'h24, 32'h20, w(8), 1'b1, 1'b0, 1'b0, 32'd6);

    // End of memory: last two words fetched, then HALT at 0x100.
    cyc("redir_f8", 1'b0, 1'b0, 1'b1, 32'hF8, 32'hF8, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd6);
    idle("word62",  32'hFC,  32'hF8, w(62), 1'b1, 1'b0, 1'b0, 32'd7);
    idle("word63",  32'h100, 32'hFC, w(63), 1'b1, 1'b0, 1'b0, 32'd8);
    idle("halt",    32'h100, 32'h0,  NOP,   1'b0, 1'b1, 1'b0, 32'd8);
    idle("halt2",   32'h100, 32'h0,  NOP,   1'b0, 1'b1, 1'b0, 32'd8);
    cyc("halt_stall", 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, NOP, 1'b0, 1'b1, 1'b0, 32'd8);
    cyc("resume_0", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd8);
    idle("resumed", 32'h4, 32'h0, w(0), 1'b1, 1'b0, 1'b0, 32'd9);

    // Misaligned redirect faults; later redirects are ignored until reset.
    cyc("misalign", 1'b0, 1'b0, 1'b1, 32'h22, 32'h4, 32'h0, NOP, 1'b0, 1'b1, 1'b1, 32'd9);
    cyc("fault_redir", 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 32'h0, NOP, 1'b0, 1'b1, 1'b1, 32'd9);
    idle("fault_hold", 32'h4, 32'h0, NOP, 1'b0, 1'b1, 1'b1, 32'd9);
    cyc("fault_rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);

    // Reset mid-operation with stall and redirect both asserted.
    cyc("redir_38", 1'b0, 1'b0, 1'b1, 32'h38, 32'h38, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
    idle("word14",  32'h3C, 32'h38, w(14), 1'b1, 1'b0, 1'b0, 32'd1);
    idle("word15",  32'h40, 32'h3C, w(15), 1'b1, 1'b0, 1'b0, 32'd2);
    cyc("rst_mid", 1'b1, 1'b1, 1'b1, 32'h80, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 32'd0);
    idle("post_rst", 32'h4, 32'h0, w(0), 1'b1, 1'b0, 1'b0, 32'd1);

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the pipelined RV32I core.
- Owns the program counter and drives the word address of the combinational instruction memory, which has 64 words and a 6-bit word address.
- Captures the returned word into the IF/ID pipeline register for the decoder.
- Honours stall and branch-redirect requests from the hazard/branch logic, inserts NOP bubbles, and halts fetch when the PC leaves the memory range.

Parameters:
- XLEN, 32, datapath/PC width.
- ADDR_W, 6, instruction-memory word-address width (2^ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0033, bubble encoding (add x0,x0,x0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit request: hold PC and IF/ID.
- branch_taken  in  1  redirect request from branch resolution.
- branch_target  in  XLEN  byte address to redirect to.
- imem_addr  out  ADDR_W  word address to instruction memory, = pc[ADDR_W+1:2].
- imem_data  in  32  instruction word from memory, combinational on imem_addr.
- if_id_pc  out  XLEN  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real fetched instruction.
- pc_out  out  XLEN  current fetch PC.
- halted  out  1  state is HALT or FAULT.
- misaligned  out  1  sticky: a redirect target had target[1:0] != 0.
- fetch_count  out  32  number of valid instructions latched into IF/ID.

Behaviour:
- Registers: pc, state, if_id_pc, if_id_instr, if_id_valid, misaligned, fetch_count.
- Everything updates on the rising edge of clk.
- imem_addr is combinational from pc. There is no other combinational path from inputs to outputs.
- Reset (rst=1 at an edge) overrides everything, including mid-stall or mid-redirect:
  - pc=RESET_PC, state=RUN.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - misaligned=0, fetch_count=0.
  - halted=0.
- Definition: oor (out of range) = |pc[XLEN-1:ADDR_W+2], i.e. pc >= 4*2^ADDR_W (256 at defaults).
- States: RUN, HALT, FAULT. Per edge, the first matching rule in priority order applies.
- 1. rst: reset as above.
- 2. FAULT: all registers hold; if_id_instr=NOP_INSTR, if_id_valid=0. Only rst exits FAULT.
- 3. branch_taken=1 (in RUN or HALT; overrides stall, since the branch is older):
  - If branch_target[1:0] != 0: misaligned<=1, state<=FAULT, IF/ID<=bubble, pc holds.
  - Otherwise: pc<=branch_target, IF/ID<=bubble (instr=NOP_INSTR, valid=0, pc=0), state<=RUN.
  - If the target is oor, the next edge moves the stage to HALT via rule 5.
- 4. stall=1: pc, IF/ID, state and fetch_count all hold.
- 5. RUN and oor: state<=HALT, IF/ID<=bubble, pc holds.
- 6. RUN, in range:
  - if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1.
  - pc<=pc+4 (mod 2^XLEN).
  - fetch_count<=fetch_count+1 (wraps at 2^32).
- 7. HALT: pc holds, IF/ID<=bubble. Only branch_taken or rst exits HALT.
- Latency: an instruction at address A is visible on if_id_instr one edge after pc==A with no stall or redirect.
- Redirect cost: exactly one bubble cycle.
- Bubble: if_id_valid=0 always pairs with if_id_instr=NOP_INSTR and if_id_pc=0.
- Out-of-range fetch (pc 0xFC -> 0x100): the word at 0xFC is fetched normally; the next edge enters HALT. The PC never aliases through imem_addr wrap-around.

Test Plan:
- Straight-line run: rst 2 cycles, then free-run 5 cycles from RESET_PC=0 with memory word0=0x00002083. Required after the 1st edge: if_id_instr=0x00002083, if_id_pc=0, valid=1. After 5 edges: pc_out=0x14, fetch_count=5.
- Stall: at pc=0x0C, hold stall=1 for 3 edges. Required: pc_out stays 0x0C, IF/ID unchanged, fetch_count unchanged. On release the next edge latches word3 with if_id_pc=0x0C.
- Redirect vs stall: at pc=0x14, apply branch_taken=1, target=0x20 and stall=1 together. Required: next edge pc=0x20 with a bubble (if_id_instr=0x00000033, valid=0). The following edge latches word8 with if_id_pc=0x20.
- End of memory: redirect to 0xF8, run 4 edges. Required:
  - words 62 and 63 latched;
  - then halted=1, pc_out=0x100, valid=0;
  - fetch_count no longer increments.
  - A redirect to 0x0 then resumes RUN, and halted=0.
- Misaligned redirect: branch_target=0x22. Required: misaligned=1, halted=1, PC frozen. A later valid redirect to 0x0 is ignored. rst clears both flags.
- Reset mid-operation: assert rst while stall=1 and branch_taken=1 at pc=0x40. Required: next edge pc_out=0, if_id_valid=0, fetch_count=0, state RUN.
